div_unit: RTL and testbench

- Iterative multi-cycle divider implementing RV32M DIV/DIVU/REM/REMU. It is the inverse companion of the combinational ALU multiply ops.
- Sits beside the ALU in EX. The pipeline stalls while busy is high and captures the result on the valid pulse.
- Radix-2 restoring algorithm, one quotient bit per cycle, on magnitudes; signs are fixed up in a final cycle.

---
 rtl/div_unit.sv | 189 ++++++++++++++++++
 tb/tb_div_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divides operand magnitudes one quotient bit per cycle (CALC), then applies
// the sign fix-up and registers the result in a single FIX cycle.
// Divide-by-zero and signed overflow skip CALC and go to FIX with the final
// value preloaded.
// Optional macro DIV_EARLY_OUT_EN: when |a| < |b| the quotient is known to be
// zero, so CALC is skipped. Results are identical either way; only latency differs.
//
// Handshake: start is accepted only on an edge where busy=0 and kill=0; the
// operands are sampled on that edge only. busy stays high until the FIX edge.
// valid is a one-cycle pulse in the cycle after the FIX edge, and result holds
// until the next valid pulse. kill aborts CALC/FIX without touching result.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int CW = $clog2(XLEN);

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            valid_q, valid_d;

  // Operand decode for the accept edge.
  logic            signed_op;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            b_zero, ovf;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[XLEN-1];
  assign b_neg     = signed_op & b[XLEN-1];
  assign abs_a     = a_neg ? (~a + 1'b1) : a;
  assign abs_b     = b_neg ? (~b + 1'b1) : b;
  assign b_zero    = (b == '0);
  assign ovf       = signed_op && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

  // One restoring step: shift {rem,quo} left, trial-subtract on XLEN+1 bits.
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  // Sign fix-up; preloaded special values bypass it.
  logic [XLEN-1:0] q_fix, r_fix, fix_val;

  assign q_fix   = (neg_a_q ^ neg_b_q) ? (~quo_q + 1'b1) : quo_q;
  assign r_fix   = neg_a_q ? (~rem_q + 1'b1) : rem_q;
  assign fix_val = special_q ? (op_q[1] ? rem_q : quo_q)
                             : (op_q[1] ? r_fix : q_fix);

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    special_d = special_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    count_d   = count_q;
    result_d  = result_q;
    valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          op_d      = op;
          neg_a_d   = a_neg;
          neg_b_d   = b_neg;
          dvs_d     = abs_b;
          count_d   = '0;
          special_d = 1'b0;
          if (b_zero) begin
            special_d = 1'b1;
            quo_d     = '1;
            rem_d     = a;
            state_d   = FIX;
          end else if (ovf) begin
            special_d = 1'b1;
            quo_d     = {1'b1, {(XLEN-1){1'b0}}};
            rem_d     = '0;
            state_d   = FIX;
`ifdef DIV_EARLY_OUT_EN
          end else if (abs_a < abs_b) begin
            quo_d     = '0;
            rem_d     = abs_a;
            state_d   = FIX;
`endif
          end else begin
            quo_d     = abs_a;
            rem_d     = '0;
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          count_d = count_q + 1'b1;
          if (count_q == CW'(XLEN-1)) state_d = FIX;
        end
      end

      FIX: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          result_d = fix_val;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      special_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      count_q   <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      special_q <= special_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      count_q   <= count_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign valid     = valid_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table plus hand-written control sequences for div_unit.
module tb_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam int FULL_LAT = 34;
  localparam int SPEC_LAT = 2;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .kill      (kill),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .valid     (valid),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and let the accept edge (E0) pass.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Count further edges until valid is observed, bounded by budget.
  task automatic wait_valid(input int budget, output int n, output bit seen);
    n    = 0;
    seen = valid;
    while (!seen && n < budget) begin
      step();
      n++;
      seen = valid;
    end
  endtask

  initial begin
    int  n;
    bit  seen;
    bit  any_valid;
    logic [31:0] prev;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         FULL_LAT};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          FULL_LAT};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  FULL_LAT};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  FULL_LAT};
    vecs[4]  = '{OP_DIV,  32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  SPEC_LAT};
    vecs[5]  = '{OP_DIVU, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  SPEC_LAT};
    vecs[6]  = '{OP_REM,  32'h1234_5678,  32'd0,          32'h1234_5678,  SPEC_LAT};
    vecs[7]  = '{OP_REMU, 32'h1234_5678,  32'd0,          32'h1234_5678,  SPEC_LAT};
    vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SPEC_LAT};
    vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  SPEC_LAT};
    vecs[10] = '{OP_DIVU, 32'd3,          32'd10,         32'd0,          EARLY_LAT};
    vecs[11] = '{OP_REMU, 32'd3,          32'd10,         32'd3,          EARLY_LAT};
    vecs[12] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  FULL_LAT};
    vecs[13] = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          FULL_LAT};
    vecs[14] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  FULL_LAT};
    vecs[15] = '{OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  FULL_LAT};
    vecs[16] = '{OP_REMU, 32'hFFFF_FFFF,  32'h10,         32'h0000_000F,  FULL_LAT};
    vecs[17] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          EARLY_LAT};

    // Reset
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; a = '0; b = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_busy",   {31'd0, busy},  32'd0);
    check("reset_valid",  {31'd0, valid}, 32'd0);
    check("reset_result", result,         32'd0);
    check("reset_state",  {30'd0, dbg_state}, 32'd0);

    // Vector table
    for (int i = 0; i < 18; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd1);
      wait_valid(60, n, seen);
      check($sformatf("vec%0d_valid_seen", i), {31'd0, seen}, 32'd1);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(1 + n), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy_at_valid", i), {31'd0, busy}, 32'd0);
      step();
      check($sformatf("vec%0d_valid_pulse", i), {31'd0, valid}, 32'd0);
    end

    // start while busy is ignored
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (9) step();
    op = OP_DIVU; a = 32'd50; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(60, n, seen);
    check("ignore_start_valid_seen", {31'd0, seen}, 32'd1);
    check("ignore_start_result", result, 32'd14);
    check("ignore_start_latency", 32'(11 + n), 32'(FULL_LAT));

    // start in the valid cycle is accepted back to back
    op = OP_REMU; a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_valid_drop", {31'd0, valid}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_valid(60, n, seen);
    check("b2b_valid_seen", {31'd0, seen}, 32'd1);
    check("b2b_result", result, 32'd2);
    check("b2b_latency", 32'(1 + n), 32'(FULL_LAT));
    step();

    // kill at cycle 5: aborts with no valid and result untouched
    prev = 32'd2;
    launch(OP_DIVU, 32'd1000, 32'd3);
    repeat (4) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_valid", {31'd0, valid}, 32'd0);
    any_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (valid) any_valid = 1'b1;
    end
    check("kill_no_valid", {31'd0, any_valid}, 32'd0);
    check("kill_result_held", result, prev);

    // rst in the middle of CALC
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (8) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy",   {31'd0, busy},  32'd0);
    check("midrst_valid",  {31'd0, valid}, 32'd0);
    check("midrst_result", result,         32'd0);

    // Divider still works after the mid-operation reset
    launch(OP_DIV, 32'd100, 32'hFFFF_FFF9);
    wait_valid(60, n, seen);
    check("post_rst_valid_seen", {31'd0, seen}, 32'd1);
    check("post_rst_result", result, 32'hFFFF_FFF2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
